// File: rtl/hdq_pkg.sv
// ---------------------------------------------------------------------------
// hdq_pkg
// Shared definitions for the HDQ transaction scheduler:
//   - state_t        : scheduler FSM state encoding
//   - RST_PULSE_CYC  : width of the hdq_rst pulse issued after every read
//   - DEF_*          : default timing / poll-list constants (133 MHz system)
//   - *_W            : counter and index widths
// ---------------------------------------------------------------------------
package hdq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_RECOVER,
        ST_DRAIN
    } state_t;

    localparam int RST_PULSE_CYC = 2;

    localparam int          DEF_NUM_POLL    = 4;
    localparam logic [31:0] DEF_POLL_ADDRS  = 32'h0C_0B_08_06;
    localparam int          DEF_PERIOD_CYC  = 13_300_000;
    localparam int          DEF_TIMEOUT_CYC = 800_000;
    localparam int          DEF_GAP_CYC     = 27_000;

    localparam int TIMER_W  = 20;
    localparam int PERIOD_W = 24;
    localparam int IDX_W    = 3;

endpackage

// File: rtl/hdq_poll_timer.sv
// ---------------------------------------------------------------------------
// hdq_poll_timer
// Free-running poll period counter. Counts while poll_en is high and is held
// at zero while poll_en is low, so re-enabling polling always yields a full
// period before the first tick.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous reset, active low
//   poll_en  in   1 = count, 0 = clear
//   tick     out  high for the single cycle in which the counter wraps
// ---------------------------------------------------------------------------
module hdq_poll_timer
    import hdq_pkg::*;
#(
    parameter int PERIOD_CYC = DEF_PERIOD_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic poll_en,
    output logic tick
);

    localparam logic [PERIOD_W-1:0] WRAP_VAL = PERIOD_W'(PERIOD_CYC - 1);

    logic [PERIOD_W-1:0] period_cnt;

    // Period counter: cleared whenever polling is disabled, wraps to zero on
    // the terminal count so successive ticks are exactly PERIOD_CYC apart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= '0;
        end else if (!poll_en) begin
            period_cnt <= '0;
        end else if (period_cnt == WRAP_VAL) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    // The tick is combinational so the scheduler sees it in the same cycle
    // the counter sits at its terminal value.
    assign tick = poll_en && (period_cnt == WRAP_VAL);

endmodule

// File: rtl/hdq_txn_scheduler.sv
// ---------------------------------------------------------------------------
// hdq_txn_scheduler
// Shares one single-shot HDQ register reader between a host port and an
// autonomous poller that refreshes a shadow register file every poll period.
// Each read is: ISSUE (start held until done or timeout) -> CAPTURE ->
// RECOVER (2-cycle hdq_rst) -> DRAIN (wait done low, then a bus gap) -> IDLE.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   poll_en                    enable periodic polling
//   host_req, host_addr        level request + address, held until host_ack
//   host_ack/host_data/host_err one-cycle result pulse, data, timeout flag
//   hdq_start/hdq_rst/hdq_addr control of the hdq_interface
//   hdq_done/hdq_data          status and read data from the hdq_interface
//   poll_data/poll_valid/poll_err shadow file, per-entry valid / timeout
//   poll_overrun               sticky: a tick landed on an unfinished round
//   busy                       scheduler is not in IDLE
// ---------------------------------------------------------------------------
module hdq_txn_scheduler
    import hdq_pkg::*;
#(
    parameter int                      NUM_POLL    = DEF_NUM_POLL,
    parameter logic [8*NUM_POLL-1:0]   POLL_ADDRS  = DEF_POLL_ADDRS,
    parameter int                      PERIOD_CYC  = DEF_PERIOD_CYC,
    parameter int                      TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int                      GAP_CYC     = DEF_GAP_CYC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  poll_en,
    input  logic                  host_req,
    input  logic [7:0]            host_addr,
    output logic                  host_ack,
    output logic [7:0]            host_data,
    output logic                  host_err,
    output logic                  hdq_start,
    output logic                  hdq_rst,
    output logic [7:0]            hdq_addr,
    input  logic                  hdq_done,
    input  logic [7:0]            hdq_data,
    output logic [8*NUM_POLL-1:0] poll_data,
    output logic [NUM_POLL-1:0]   poll_valid,
    output logic [NUM_POLL-1:0]   poll_err,
    output logic                  poll_overrun,
    output logic                  busy
);

    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYC - 1);
    localparam logic [TIMER_W-1:0] GAP_LAST     = TIMER_W'(GAP_CYC - 1);
    localparam logic [1:0]         RST_LAST     = 2'(RST_PULSE_CYC - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX     = IDX_W'(NUM_POLL - 1);

    state_t               state;
    logic [TIMER_W-1:0]   timer;
    logic [1:0]           rst_cnt;
    logic [IDX_W-1:0]     poll_idx;
    logic                 poll_pending;
    logic                 last_was_host;
    logic                 cur_host;
    logic                 tick;
    logic [7:0]           poll_addr_sel;
    logic [NUM_POLL-1:0]  idx_mask;

    hdq_poll_timer #(
        .PERIOD_CYC (PERIOD_CYC)
    ) u_poll_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .poll_en (poll_en),
        .tick    (tick)
    );

    // Address of the poll entry currently due, plus a one-hot mask of that
    // entry for updating the per-entry valid / error flags.
    always_comb begin
        poll_addr_sel = '0;
        for (int i = 0; i < NUM_POLL; i++) begin
            if (poll_idx == IDX_W'(i)) begin
                poll_addr_sel = POLL_ADDRS[8*i +: 8];
            end
        end
        idx_mask = NUM_POLL'(1) << poll_idx;
    end

    // Scheduler FSM. All outputs are registered and are set on the edge that
    // enters the state they belong to. One timer serves both the no-response
    // timeout (ISSUE) and the bus gap (DRAIN) since they never overlap.
    // Reset lands in DRAIN so the interface is reset and the bus is given a
    // full gap before the first transaction after power-up or a mid-read reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_DRAIN;
            timer         <= '0;
            rst_cnt       <= '0;
            poll_idx      <= '0;
            poll_pending  <= 1'b0;
            last_was_host <= 1'b0;
            cur_host      <= 1'b0;
            hdq_start     <= 1'b0;
            hdq_rst       <= 1'b1;
            hdq_addr      <= '0;
            host_ack      <= 1'b0;
            host_data     <= '0;
            host_err      <= 1'b0;
            poll_data     <= '0;
            poll_valid    <= '0;
            poll_err      <= '0;
            poll_overrun  <= 1'b0;
            busy          <= 1'b1;
        end else begin
            host_ack <= 1'b0;

            // A tick either opens a new round or, if the previous round is
            // still running, is dropped and flagged as an overrun.
            if (tick) begin
                if (poll_pending) begin
                    poll_overrun <= 1'b1;
                end else begin
                    poll_pending <= 1'b1;
                    poll_idx     <= '0;
                end
            end

            case (state)
                ST_IDLE: begin
                    hdq_rst <= 1'b0;
                    // Host wins unless it had the previous slot and a poll is
                    // waiting; this alternation keeps either side from starving.
                    if (host_req && !(poll_pending && last_was_host)) begin
                        state         <= ST_ISSUE;
                        busy          <= 1'b1;
                        hdq_start     <= 1'b1;
                        hdq_addr      <= host_addr;
                        cur_host      <= 1'b1;
                        last_was_host <= 1'b1;
                        timer         <= '0;
                    end else if (poll_pending && poll_en) begin
                        state         <= ST_ISSUE;
                        busy          <= 1'b1;
                        hdq_start     <= 1'b1;
                        hdq_addr      <= poll_addr_sel;
                        cur_host      <= 1'b0;
                        last_was_host <= 1'b0;
                        timer         <= '0;
                    end else if (poll_pending) begin
                        // Polling was switched off between entries of a round.
                        poll_pending <= 1'b0;
                        poll_idx     <= '0;
                    end
                end

                ST_ISSUE: begin
                    if (hdq_done) begin
                        state <= ST_CAPTURE;
                    end else if (timer == TIMEOUT_LAST) begin
                        state     <= ST_RECOVER;
                        hdq_start <= 1'b0;
                        hdq_rst   <= 1'b1;
                        rst_cnt   <= '0;
                        if (cur_host) begin
                            host_ack  <= 1'b1;
                            host_err  <= 1'b1;
                            host_data <= 8'h00;
                        end else begin
                            poll_err <= poll_err | idx_mask;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                ST_CAPTURE: begin
                    state     <= ST_RECOVER;
                    hdq_start <= 1'b0;
                    hdq_rst   <= 1'b1;
                    rst_cnt   <= '0;
                    if (cur_host) begin
                        host_ack  <= 1'b1;
                        host_err  <= 1'b0;
                        host_data <= hdq_data;
                    end else begin
                        for (int i = 0; i < NUM_POLL; i++) begin
                            if (poll_idx == IDX_W'(i)) begin
                                poll_data[8*i +: 8] <= hdq_data;
                            end
                        end
                        poll_valid <= poll_valid | idx_mask;
                        poll_err   <= poll_err & ~idx_mask;
                    end
                end

                ST_RECOVER: begin
                    if (rst_cnt == RST_LAST) begin
                        state   <= ST_DRAIN;
                        hdq_rst <= 1'b0;
                        timer   <= '0;
                        // A finished poll read advances the round; the round
                        // ends after the last entry or if polling was disabled.
                        if (!cur_host) begin
                            if ((poll_idx == LAST_IDX) || !poll_en) begin
                                poll_pending <= 1'b0;
                                poll_idx     <= '0;
                            end else begin
                                poll_idx <= poll_idx + 1'b1;
                            end
                        end
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end

                ST_DRAIN: begin
                    hdq_rst <= 1'b0;
                    // The gap only counts consecutive cycles with done low.
                    if (hdq_done) begin
                        timer <= '0;
                    end else if (timer == GAP_LAST) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                default: begin
                    state     <= ST_DRAIN;
                    hdq_start <= 1'b0;
                    hdq_rst   <= 1'b1;
                    timer     <= '0;
                    busy      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hdq_txn_scheduler.sv
// ---------------------------------------------------------------------------
// tb_hdq_txn_scheduler
// Directed bench for hdq_txn_scheduler with a behavioural hdq_interface model.
// Expected bus addresses and host results are queued by the stimulus and
// popped by a monitor whenever the DUT starts a read or pulses host_ack.
// ---------------------------------------------------------------------------
module tb_hdq_txn_scheduler;

    localparam int          NUM_POLL    = 2;
    localparam logic [15:0] POLL_ADDRS  = 16'h0C_08;
    localparam int          PERIOD_CYC  = 5000;
    localparam int          TIMEOUT_CYC = 500;
    localparam int          GAP_CYC     = 20;
    localparam int          LAT         = 10;
    localparam int          STUCK_CYC   = 6000;

    logic        clk;
    logic        rst_n;
    logic        poll_en;
    logic        host_req;
    logic [7:0]  host_addr;
    logic        host_ack;
    logic [7:0]  host_data;
    logic        host_err;
    logic        hdq_start;
    logic        hdq_rst;
    logic [7:0]  hdq_addr;
    logic        hdq_done;
    logic [7:0]  hdq_data;
    logic [15:0] poll_data;
    logic [1:0]  poll_valid;
    logic [1:0]  poll_err;
    logic        poll_overrun;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int ack_seen = 0;
    int last_start_len = 0;

    logic [7:0] exp_addr_q[$];
    logic [8:0] exp_host_q[$];

    // Model controls, written only by the stimulus process
    logic [7:0] no_resp_addr = 8'hFF;
    logic       stuck_req    = 1'b0;
    logic       hold_done    = 1'b0;
    logic [7:0] data08       = 8'h5A;
    logic [7:0] data0c       = 8'hA5;
    logic [7:0] data20       = 8'h3C;

    hdq_txn_scheduler #(
        .NUM_POLL    (NUM_POLL),
        .POLL_ADDRS  (POLL_ADDRS),
        .PERIOD_CYC  (PERIOD_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .GAP_CYC     (GAP_CYC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .poll_en      (poll_en),
        .host_req     (host_req),
        .host_addr    (host_addr),
        .host_ack     (host_ack),
        .host_data    (host_data),
        .host_err     (host_err),
        .hdq_start    (hdq_start),
        .hdq_rst      (hdq_rst),
        .hdq_addr     (hdq_addr),
        .hdq_done     (hdq_done),
        .hdq_data     (hdq_data),
        .poll_data    (poll_data),
        .poll_valid   (poll_valid),
        .poll_err     (poll_err),
        .poll_overrun (poll_overrun),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global safety net in case a bounded wait is itself never reached
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic req, input logic [7:0] addr);
        poll_en   = en;
        host_req  = req;
        host_addr = addr;
    endtask

    // ---------------- hdq_interface model ----------------
    // Asserts done LAT cycles after start (unless the address is marked
    // non-responding), done is sticky until hdq_rst. On request it keeps done
    // stuck high for STUCK_CYC cycles after one reset to stretch DRAIN.
    logic       model_done = 1'b0;
    logic [7:0] model_data = 8'h00;
    int         lat_cnt    = 0;
    int         stuck_cnt  = 0;
    logic       stuck_used = 1'b0;

    assign hdq_done = model_done | hold_done;
    assign hdq_data = model_data;

    function automatic logic [7:0] lookup(input logic [7:0] a);
        case (a)
            8'h08:   return data08;
            8'h0C:   return data0c;
            8'h20:   return data20;
            default: return 8'hEE;
        endcase
    endfunction

    always @(posedge clk) begin
        if (stuck_cnt > 0) begin
            stuck_cnt <= stuck_cnt - 1;
            lat_cnt   <= 0;
            if (stuck_cnt == 1) model_done <= 1'b0;
        end else if (hdq_rst) begin
            lat_cnt <= 0;
            if (model_done && stuck_req && !stuck_used) begin
                stuck_cnt  <= STUCK_CYC;
                stuck_used <= 1'b1;
            end else begin
                model_done <= 1'b0;
            end
        end else if (hdq_start && !model_done) begin
            if (lat_cnt == LAT - 1 && hdq_addr != no_resp_addr) begin
                model_done <= 1'b1;
                model_data <= lookup(hdq_addr);
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic prev_start = 1'b0;
        logic prev_rst   = 1'b0;
        logic in_pulse   = 1'b0;
        int   start_len  = 0;
        int   rst_len    = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (hdq_start && !prev_start) begin
                    if (exp_addr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL start_addr: unexpected start, addr %0h, none expected", hdq_addr);
                    end else begin
                        checkOutput("start_addr", 32'(hdq_addr), 32'(exp_addr_q.pop_front()));
                    end
                end
                if (hdq_start) begin
                    start_len++;
                end else if (prev_start) begin
                    last_start_len = start_len;
                    start_len = 0;
                end
                if (host_ack) begin
                    ack_seen++;
                    if (exp_host_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL host_result: unexpected host_ack, data %0h err %0b", host_data, host_err);
                    end else begin
                        checkOutput("host_result", 32'({host_err, host_data}), 32'(exp_host_q.pop_front()));
                    end
                end
                if (hdq_rst && !prev_rst) begin
                    in_pulse = 1'b1;
                    rst_len  = 0;
                end
                if (hdq_rst && in_pulse) rst_len++;
                if (!hdq_rst && prev_rst && in_pulse) begin
                    checkOutput("rst_pulse_len", 32'(rst_len), 32'd2);
                    in_pulse = 1'b0;
                end
            end else begin
                in_pulse  = 1'b0;
                start_len = 0;
            end
            prev_start = hdq_start;
            prev_rst   = hdq_rst;
        end
    end

    // Wait until every queued transaction has been seen and the DUT is idle
    task automatic waitDone(input string name, input int bound);
        int n = 0;
        while (!(exp_addr_q.size() == 0 && exp_host_q.size() == 0 && busy == 1'b0) && n < bound) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 32'(n < bound), 32'd1);
    endtask

    task automatic waitAcks(input string name, input int target, input int bound);
        int n = 0;
        while (ack_seen < target && n < bound) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 32'(ack_seen >= target), 32'd1);
    endtask

    task automatic hostRead(input string name, input logic [7:0] addr,
                            input logic [7:0] exp_data, input logic exp_err);
        int base = ack_seen;
        exp_addr_q.push_back(addr);
        exp_host_q.push_back({exp_err, exp_data});
        applyStimulus(poll_en, 1'b1, addr);
        waitAcks({name, "_ack"}, base + 1, 2000);
        host_req = 1'b0;
        waitDone({name, "_done"}, 500);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int base;
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00);
        repeat (3) @(negedge clk);

        // Reset state
        checkOutput("rst_hdq_rst",   32'(hdq_rst),      32'd1);
        checkOutput("rst_hdq_start", 32'(hdq_start),    32'd0);
        checkOutput("rst_hdq_addr",  32'(hdq_addr),     32'd0);
        checkOutput("rst_busy",      32'(busy),         32'd1);
        checkOutput("rst_host_ack",  32'(host_ack),     32'd0);
        checkOutput("rst_poll_data", 32'(poll_data),    32'd0);
        checkOutput("rst_poll_flags",32'({poll_overrun, poll_err, poll_valid}), 32'd0);
        rst_n = 1'b1;
        waitDone("boot_idle", 100);
        checkOutput("boot_hdq_rst_low", 32'(hdq_rst), 32'd0);

        // 1: one poll round
        $display("[TB] test 1: poll round");
        exp_addr_q.push_back(8'h08);
        exp_addr_q.push_back(8'h0C);
        applyStimulus(1'b1, 1'b0, 8'h00);
        waitDone("t1_round", 7000);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("t1_poll_data",  32'(poll_data),    32'h0000_A55A);
        checkOutput("t1_poll_valid", 32'(poll_valid),   32'd3);
        checkOutput("t1_poll_err",   32'(poll_err),     32'd0);
        checkOutput("t1_overrun",    32'(poll_overrun), 32'd0);

        // 2: single host read
        $display("[TB] test 2: host read");
        hostRead("t2", 8'h20, 8'h3C, 1'b0);
        checkOutput("t2_host_data_hold", 32'(host_data), 32'h3C);

        // 3: host request and tick in the same cycle
        $display("[TB] test 3: arbitration");
        data08 = 8'h11;
        data0c = 8'h22;
        data20 = 8'hC3;
        exp_addr_q.push_back(8'h20);
        exp_addr_q.push_back(8'h08);
        exp_addr_q.push_back(8'h20);
        exp_addr_q.push_back(8'h0C);
        exp_host_q.push_back({1'b0, 8'hC3});
        exp_host_q.push_back({1'b0, 8'hC3});
        base = ack_seen;
        applyStimulus(1'b1, 1'b0, 8'h20);
        repeat (PERIOD_CYC - 1) @(negedge clk);
        host_req = 1'b1;
        waitAcks("t3_two_acks", base + 2, 3000);
        host_req = 1'b0;
        waitDone("t3_round", 3000);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("t3_poll_data",  32'(poll_data),  32'h0000_2211);
        checkOutput("t3_poll_valid", 32'(poll_valid), 32'd3);

        // 4: poll entry 0x0C never answers, then a host read times out
        $display("[TB] test 4: timeouts");
        data08       = 8'h44;
        no_resp_addr = 8'h0C;
        exp_addr_q.push_back(8'h08);
        exp_addr_q.push_back(8'h0C);
        applyStimulus(1'b1, 1'b0, 8'h00);
        waitDone("t4_round", 7000);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("t4_start_len",  32'(last_start_len), 32'd500);
        checkOutput("t4_poll_err",   32'(poll_err),       32'd2);
        checkOutput("t4_poll_data",  32'(poll_data),      32'h0000_2244);
        checkOutput("t4_poll_valid", 32'(poll_valid),     32'd3);
        no_resp_addr = 8'h30;
        hostRead("t4_host", 8'h30, 8'h00, 1'b1);
        checkOutput("t4_host_start_len", 32'(last_start_len), 32'd500);
        checkOutput("t4_host_err_hold",  32'(host_err),       32'd1);

        // 5: round stretched past the period -> overrun, round not restarted
        $display("[TB] test 5: overrun");
        no_resp_addr = 8'hFF;
        data08       = 8'h55;
        data0c       = 8'h66;
        stuck_req    = 1'b1;
        exp_addr_q.push_back(8'h08);
        exp_addr_q.push_back(8'h0C);
        applyStimulus(1'b1, 1'b0, 8'h00);
        waitDone("t5_round", 15000);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("t5_overrun",   32'(poll_overrun), 32'd1);
        checkOutput("t5_poll_data", 32'(poll_data),    32'h0000_6655);
        checkOutput("t5_poll_err",  32'(poll_err),     32'd0);
        repeat (10) @(negedge clk);
        checkOutput("t5_overrun_sticky", 32'(poll_overrun), 32'd1);

        // 6: reset while a read is in ISSUE
        $display("[TB] test 6: reset mid-read");
        no_resp_addr = 8'h20;
        exp_addr_q.push_back(8'h20);
        applyStimulus(1'b0, 1'b1, 8'h20);
        n = 0;
        while (!hdq_start && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t6_started", 32'(hdq_start), 32'd1);
        host_req = 1'b0;
        repeat (50) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_start_cleared", 32'(hdq_start), 32'd0);
        checkOutput("t6_rst_asserted",  32'(hdq_rst),   32'd1);
        checkOutput("t6_busy",          32'(busy),      32'd1);
        hold_done = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        checkOutput("t6_held_off", 32'({busy, hdq_start}), 32'd2);
        no_resp_addr = 8'hFF;
        data20       = 8'h9D;
        exp_addr_q.push_back(8'h20);
        exp_host_q.push_back({1'b0, 8'h9D});
        base = ack_seen;
        applyStimulus(1'b0, 1'b1, 8'h20);
        hold_done = 1'b0;
        n = 0;
        while (!hdq_start && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t6_gap_delay", 32'(n), 32'd21);
        waitAcks("t6_ack", base + 1, 500);
        host_req = 1'b0;
        waitDone("t6_done", 500);

        checkOutput("queues_empty", 32'(exp_addr_q.size() + exp_host_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
